// File: rtl/tone_synth_i2s_pkg.sv
// Shared types and default constants for the I2S tone synthesizer.
package tone_pkg;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'b00,
        WAVE_SAW    = 2'b01,
        WAVE_TRI    = 2'b10,
        WAVE_SILENT = 2'b11
    } wave_e;

    localparam int CLK_HZ  = 100_000_000;
    localparam int FS_HZ   = 31_250;
    localparam int PHASE_K = 537;

    typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/tone_synth_i2s_tx.sv
// I2S transmitter: clock-enable MCLK/SCLK/LRCK dividers and a
// left-justified MSB-first shifter; flags the start of each frame.
module i2s_tx #(
    parameter int SAMPLE_BITS = 16,
    parameter int MCLK_HALF   = 25,
    parameter int SCLK_HALF   = 50
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SAMPLE_BITS-1:0] left_word,
    input  logic [SAMPLE_BITS-1:0] right_word,
    output logic                   frame_start,
    output logic                   mclk,
    output logic                   sclk,
    output logic                   lrck,
    output logic                   sdata
);

    localparam int MW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam int SW = $clog2(SCLK_HALF);
    localparam int BW = $clog2(SAMPLE_BITS);

    logic [MW-1:0]          mclk_cnt_q, mclk_cnt_d;
    logic [SW-1:0]          sclk_cnt_q, sclk_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    logic                   mclk_q, mclk_d;
    logic                   sclk_q, sclk_d;
    logic                   lrck_q, lrck_d;
    logic                   sdata_q, sdata_d;
    logic                   mclk_wrap, sclk_wrap, fall;
    logic [SAMPLE_BITS-1:0] word;

    always_comb begin
        mclk_wrap   = (mclk_cnt_q == MW'(MCLK_HALF - 1));
        sclk_wrap   = (sclk_cnt_q == SW'(SCLK_HALF - 1));
        fall        = sclk_wrap & sclk_q;
        mclk_cnt_d  = mclk_wrap ? '0 : mclk_cnt_q + 1'b1;
        sclk_cnt_d  = sclk_wrap ? '0 : sclk_cnt_q + 1'b1;
        mclk_d      = mclk_q ^ mclk_wrap;
        sclk_d      = sclk_q ^ sclk_wrap;
        bit_cnt_d   = bit_cnt_q;
        lrck_d      = lrck_q;
        shift_d     = shift_q;
        sdata_d     = sdata_q;
        word        = lrck_q ? left_word : right_word;
        frame_start = fall && (bit_cnt_q == '0) && lrck_q;
        if (fall) begin
            bit_cnt_d = (bit_cnt_q == BW'(SAMPLE_BITS - 1)) ?
                        '0 : bit_cnt_q + 1'b1;
            // Word boundary: switch channel and present its MSB at once.
            if (bit_cnt_q == '0) begin
                lrck_d  = ~lrck_q;
                sdata_d = word[SAMPLE_BITS-1];
                shift_d = word << 1;
            end else begin
                sdata_d = shift_q[SAMPLE_BITS-1];
                shift_d = shift_q << 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mclk_cnt_q <= '0;
            sclk_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            mclk_q     <= 1'b0;
            sclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            sdata_q    <= 1'b0;
        end else begin
            mclk_cnt_q <= mclk_cnt_d;
            sclk_cnt_q <= sclk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            mclk_q     <= mclk_d;
            sclk_q     <= sclk_d;
            lrck_q     <= lrck_d;
            sdata_q    <= sdata_d;
        end
    end

    assign mclk  = mclk_q;
    assign sclk  = sclk_q;
    assign lrck  = lrck_q;
    assign sdata = sdata_q;

endmodule

// File: rtl/tone_synth_i2s.sv
// Phase-accumulator tone synthesizer (square/saw/triangle) with a
// retriggerable note timer, feeding an I2S DAC via i2s_tx.
module tone_synth_i2s #(
    parameter int                     SAMPLE_BITS = 16,
    parameter int                     PHASE_W     = 24,
    parameter int                     PHASE_K     = 537,
    parameter int                     MCLK_HALF   = 25,
    parameter int                     SCLK_HALF   = 50,
    parameter int                     DUR_CYCLES  = 50_000_000,
    parameter logic [SAMPLE_BITS-1:0] AMP         = 'h0FFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        note_start,
    input  logic [11:0] freq,
    input  logic [1:0]  wave_sel,
    input  logic [1:0]  ch_en,
    output logic        busy,
    output logic        sample_tick,
    output logic        mclk,
    output logic        lrck,
    output logic        sclk,
    output logic        sdata
);

    import tone_pkg::*;

    localparam int N  = SAMPLE_BITS;
    localparam int DW = (DUR_CYCLES > 1) ? $clog2(DUR_CYCLES) : 1;

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] inc_q, inc_d;
    wave_e              wave_q, wave_d;
    logic [DW-1:0]      dur_q, dur_d;
    logic               busy_q, busy_d;
    logic [N-1:0]       left_q, left_d;
    logic [N-1:0]       right_q, right_d;
    logic [N-1:0]       sample, saw_w, tri_w;
    logic               frame_start;

    always_comb begin
        saw_w        = phase_q[PHASE_W-1 -: N];
        saw_w[N-1]   = ~saw_w[N-1];
        // Fold the upper half of the cycle to get a symmetric ramp.
        tri_w        = phase_q[PHASE_W-1] ? ~phase_q[PHASE_W-2 -: N]
                                          :  phase_q[PHASE_W-2 -: N];
        tri_w[N-1]   = ~tri_w[N-1];
        sample       = '0;
        if (busy_q && (inc_q != '0)) begin
            unique case (wave_q)
                WAVE_SQUARE: sample = phase_q[PHASE_W-1] ?
                                      (~AMP + N'(1)) : AMP;
                WAVE_SAW:    sample = saw_w;
                WAVE_TRI:    sample = tri_w;
                WAVE_SILENT: sample = '0;
            endcase
        end
    end

    always_comb begin
        phase_d = phase_q;
        inc_d   = inc_q;
        wave_d  = wave_q;
        dur_d   = dur_q;
        busy_d  = busy_q;
        left_d  = left_q;
        right_d = right_q;
        if (frame_start) begin
            phase_d = phase_q + inc_q;
            left_d  = ch_en[0] ? sample : '0;
            right_d = ch_en[1] ? sample : '0;
        end
        if (busy_q) begin
            if (dur_q == '0) busy_d = 1'b0;
            else             dur_d  = dur_q - 1'b1;
        end
        // A start beats expiry; phase only restarts from idle.
        if (note_start) begin
            inc_d  = PHASE_W'(freq) * PHASE_W'(PHASE_K);
            wave_d = wave_e'(wave_sel);
            dur_d  = DW'(DUR_CYCLES - 1);
            busy_d = 1'b1;
            if (!busy_q) phase_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            inc_q   <= '0;
            wave_q  <= WAVE_SILENT;
            dur_q   <= '0;
            busy_q  <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            phase_q <= phase_d;
            inc_q   <= inc_d;
            wave_q  <= wave_d;
            dur_q   <= dur_d;
            busy_q  <= busy_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    i2s_tx #(
        .SAMPLE_BITS (SAMPLE_BITS),
        .MCLK_HALF   (MCLK_HALF),
        .SCLK_HALF   (SCLK_HALF)
    ) u_tx (
        .clk         (clk),
        .rst_n       (rst_n),
        .left_word   (left_d),
        .right_word  (right_d),
        .frame_start (frame_start),
        .mclk        (mclk),
        .sclk        (sclk),
        .lrck        (lrck),
        .sdata       (sdata)
    );

    assign busy        = busy_q;
    assign sample_tick = frame_start;

endmodule

// File: tb/tb_tone_synth_i2s.sv
// Scoreboard bench: frame-level reference model vs words decoded from the I2S pins.
module tb_tone_synth_i2s;

    localparam int DUR      = 10000;
    localparam int K        = 537;
    localparam int AMPV     = 4095;
    localparam int FIRST_FS = 1700;
    localparam int FRAME    = 3200;
    localparam int PMASK    = 24'hFFFFFF;

    logic        clk;
    logic        rst_n;
    logic        note_start;
    logic [11:0] freq;
    logic [1:0]  wave_sel;
    logic [1:0]  ch_en;
    logic        busy, sample_tick, mclk, lrck, sclk, sdata;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   frames_checked = 0;

    tone_synth_i2s #(.DUR_CYCLES(DUR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .note_start  (note_start),
        .freq        (freq),
        .wave_sel    (wave_sel),
        .ch_en       (ch_en),
        .busy        (busy),
        .sample_tick (sample_tick),
        .mclk        (mclk),
        .lrck        (lrck),
        .sclk        (sclk),
        .sdata       (sdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_fs(input int e);
        return (e >= FIRST_FS) && ((e - FIRST_FS) % FRAME == 0);
    endfunction

    function automatic int ref_sample(input int ph, input int inc,
                                      input int wv, input bit act);
        int u, t;
        if (!act || inc == 0 || wv == 3) return 0;
        case (wv)
            0: return (ph < (1 << 23)) ? AMPV : -AMPV;
            1: return (ph >> 8) - 32768;
            default: begin
                u = (ph >> 7) & 16'hFFFF;
                t = (ph >> 23) != 0 ? 65535 - u : u;
                return t - 32768;
            end
        endcase
    endfunction

    // Reference model: edge-indexed, note lifetime as an interval.
    initial begin : model
        int e, last, m_phase, m_inc, m_wave, nph, s;
        bit have, busy_b, m_busy, m_tick;
        exp_t x;
        e = 0; last = 0; m_phase = 0; m_inc = 0; m_wave = 3;
        have = 0; m_busy = 0; m_tick = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                e = 0; have = 0; m_phase = 0; m_inc = 0; m_wave = 3;
                m_busy = 0; m_tick = 0;
                exp_q.delete();
            end else begin
                e++;
                busy_b = have && e >= last + 1 && e <= last + DUR;
                nph = m_phase;
                if (is_fs(e)) begin
                    s = ref_sample(m_phase, m_inc, m_wave, busy_b);
                    x.l = ch_en[0] ? 16'(s) : 16'h0;
                    x.r = ch_en[1] ? 16'(s) : 16'h0;
                    exp_q.push_back(x);
                    nph = (m_phase + m_inc) & PMASK;
                end
                if (note_start) begin
                    if (!busy_b) nph = 0;
                    m_inc  = (int'(freq) * K) & PMASK;
                    m_wave = int'(wave_sel);
                    last   = e;
                    have   = 1;
                end
                m_phase = nph;
                m_busy  = have && e >= last && e <= last + DUR - 1;
                m_tick  = is_fs(e + 1);
            end
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0;
                m_tick = 0;
            end
            chk("busy", 32'(busy), 32'(m_busy));
            chk("sample_tick", 32'(sample_tick), 32'(m_tick));
        end
    end

    // Monitor: decode left-justified words from the pins, pop and compare.
    initial begin : monitor
        logic [15:0] sh, lw;
        int nb;
        bit have_left, prev_sclk, prev_lrck, cur;
        exp_t x;
        sh = '0; lw = '0; nb = 0; have_left = 0;
        prev_sclk = 0; prev_lrck = 0; cur = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nb = 0; have_left = 0;
                prev_sclk = 0; prev_lrck = 0; cur = 0;
            end else begin
                if (lrck !== prev_lrck) begin
                    nb  = 0;
                    cur = lrck;
                end
                if (sclk && !prev_sclk) begin
                    sh = {sh[14:0], sdata};
                    nb++;
                    if (nb == 16) begin
                        if (!cur) begin
                            lw = sh;
                            have_left = 1;
                        end else if (have_left) begin
                            have_left = 0;
                            if (exp_q.size() == 0) begin
                                chk("frame_expected", 0, 1);
                            end else begin
                                x = exp_q.pop_front();
                                chk("left_word", 32'(lw), 32'(x.l));
                                chk("right_word", 32'(sh), 32'(x.r));
                                frames_checked++;
                            end
                        end
                    end
                end
                prev_sclk = sclk;
                prev_lrck = lrck;
            end
        end
    end

    task automatic pulse(input logic [11:0] f, input logic [1:0] w);
        freq       = f;
        wave_sel   = w;
        note_start = 1'b1;
        @(negedge clk);
        note_start = 1'b0;
        freq       = 12'($urandom);
        wave_sel   = 2'($urandom);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        repeat (120000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin : stim
        int n, f2, w;
        rst_n = 1'b0; note_start = 1'b0; freq = '0; wave_sel = '0;
        ch_en = 2'b11;
        wait_cyc(3);
        chk("reset_outputs", {26'd0, mclk, sclk, lrck, sdata, busy, sample_tick}, 0);
        rst_n = 1'b1;

        n = 0;
        while (sclk !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        chk("sclk_first_rise", n, 50);
        while (lrck !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        chk("lrck_first_toggle", n, 100);
        while (sample_tick !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        chk("first_tick", n, FIRST_FS - 1);
        n = 0;
        do begin @(negedge clk); n++; end
        while (sample_tick !== 1'b1 && n < 5000);
        chk("frame_period", n, FRAME);

        // Square note, then retrigger exactly when the timer hits zero.
        pulse(12'($urandom_range(2500, 4095)), 2'b00);
        chk("busy_after_start", 32'(busy), 1);
        wait_cyc(DUR - 1);
        f2 = $urandom_range(1000, 2000);
        pulse(12'(f2), 2'b01);
        chk("busy_after_edge_retrigger", 32'(busy), 1);

        // Double the frequency mid-note without a phase reset.
        wait_cyc(5000);
        pulse(12'(2 * f2), 2'b01);
        n = 0;
        while (busy === 1'b1 && n < DUR + 10) begin @(negedge clk); n++; end
        chk("busy_length", n, DUR);
        wait_cyc(2 * FRAME);

        // Saw on the left channel only.
        ch_en = 2'b01;
        pulse(12'd1000, 2'b01);
        wait_cyc(3500);

        // Silent cases: triangle at 0 Hz, and wave 11.
        ch_en = 2'b11;
        pulse(12'd0, 2'b10);
        wait_cyc(3300);
        pulse(12'd440, 2'b11);
        wait_cyc(3300);
        pulse(12'($urandom_range(1500, 4095)), 2'b10);
        wait_cyc(3300);

        // Asynchronous reset mid-frame.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrun_reset_outputs",
               {26'd0, mclk, sclk, lrck, sdata, busy, sample_tick}, 0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(1700);

        for (int i = 0; i < 3; i++) begin
            w = $urandom_range(0, 3);
            pulse(12'($urandom_range(200, 4095)), 2'(w));
            wait_cyc($urandom_range(1000, 3000));
            ch_en = 2'($urandom);
            wait_cyc($urandom_range(1000, 3000));
        end
        n = 0;
        while (busy === 1'b1 && n < DUR + 10) begin @(negedge clk); n++; end
        wait_cyc(3500);
        chk("frames_seen", 32'(frames_checked >= 12), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
